// File: rtl/onehot_to_index.sv
// One-hot to binary index encoder: combinational index/valid/multi-hot plus a
// registered copy and a sticky multi-hot error flag.
module onehot_to_index #(
  parameter int    NUM_SIGNALS = 4,
  parameter string DIRECTION   = "LSB0",
  localparam int   INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SIGNALS-1:0] one_hot,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   valid,
  output logic                   multi_hot,
  output logic [INDEX_WIDTH-1:0] index_q,
  output logic                   valid_q,
  output logic                   error_q
);

  localparam bit MSB_FIRST = (DIRECTION == "MSB0");

  function automatic logic [INDEX_WIDTH-1:0] map_idx(input int pos);
    if (MSB_FIRST) return INDEX_WIDTH'(NUM_SIGNALS - 1 - pos);
    else           return INDEX_WIDTH'(pos);
  endfunction

  logic [INDEX_WIDTH-1:0] index_d;
  logic                   seen_d;
  logic                   multi_d;
  logic                   error_d;

  // OR of mapped positions (not a priority encoder); a second set bit flags multi-hot.
  always_comb begin
    index_d = '0;
    seen_d  = 1'b0;
    multi_d = 1'b0;
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      if (one_hot[i]) begin
        index_d = index_d | map_idx(i);
        if (seen_d) multi_d = 1'b1;
        seen_d = 1'b1;
      end
    end
  end

  assign index     = index_d;
  assign valid     = seen_d;
  assign multi_hot = multi_d;
  assign error_d   = error_q | multi_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      index_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      index_q <= index_d;
      valid_q <= seen_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_onehot_to_index.sv
// Self-checking bench for onehot_to_index: NUM_SIGNALS=7 in both bit orders,
// directed scenarios plus randomized stimulus against a behavioural model.
module tb_onehot_to_index;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] one_hot;

  logic [2:0] idx_l, idxq_l, idx_m, idxq_m;
  logic       val_l, mh_l, valq_l, err_l;
  logic       val_m, mh_m, valq_m, err_m;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the registered outputs
  int e_iq_l, e_iq_m;
  bit e_vq, e_err;

  always #5 clk = ~clk;

  onehot_to_index #(.NUM_SIGNALS(7), .DIRECTION("LSB0")) dut_lsb (
    .clk(clk), .reset(reset), .one_hot(one_hot),
    .index(idx_l), .valid(val_l), .multi_hot(mh_l),
    .index_q(idxq_l), .valid_q(valq_l), .error_q(err_l)
  );

  onehot_to_index #(.NUM_SIGNALS(7), .DIRECTION("MSB0")) dut_msb (
    .clk(clk), .reset(reset), .one_hot(one_hot),
    .index(idx_m), .valid(val_m), .multi_hot(mh_m),
    .index_q(idxq_m), .valid_q(valq_m), .error_q(err_m)
  );

  function automatic int ref_idx(input logic [6:0] v, input bit msb);
    int r = 0;
    for (int i = 0; i < 7; i++)
      if (v[i]) r = r | (msb ? (6 - i) : i);
    return r;
  endfunction

  function automatic bit ref_multi(input logic [6:0] v);
    return $countones(v) >= 2;
  endfunction

  task automatic drive(input logic [6:0] v, input logic r);
    @(negedge clk);
    one_hot = v;
    reset   = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      e_iq_l = 0; e_iq_m = 0; e_vq = 0; e_err = 0;
    end else begin
      e_iq_l = ref_idx(one_hot, 1'b0);
      e_iq_m = ref_idx(one_hot, 1'b1);
      e_vq   = (one_hot != 0);
      e_err  = e_err | ref_multi(one_hot);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(7'h0, 1'b0);
    tick();
    tick();
    n_checks++;
    if (idxq_l !== 3'd0 || valq_l !== 1'b0 || err_l !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lsb: got iq=%0d vq=%0b err=%0b expected 0 0 0", idxq_l, valq_l, err_l);
    end
    n_checks++;
    if (idxq_m !== 3'd0 || valq_m !== 1'b0 || err_m !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_msb: got iq=%0d vq=%0b err=%0b expected 0 0 0", idxq_m, valq_m, err_m);
    end
  endtask

  task automatic test_walk();
    for (int i = 0; i < 7; i++) begin
      drive(7'(1 << i), 1'b1);
      n_checks++;
      if (idx_l !== 3'(i)) begin
        n_fail++;
        $display("FAIL walk_lsb[%0d]: got %0d expected %0d", i, idx_l, i);
      end
      n_checks++;
      if (idx_m !== 3'(6 - i)) begin
        n_fail++;
        $display("FAIL walk_msb[%0d]: got %0d expected %0d", i, idx_m, 6 - i);
      end
      n_checks++;
      if (val_l !== 1'b1 || mh_l !== 1'b0) begin
        n_fail++;
        $display("FAIL walk_flags[%0d]: got valid=%0b multi=%0b expected 1 0", i, val_l, mh_l);
      end
      tick();
      n_checks++;
      if (idxq_l !== 3'(i) || idxq_m !== 3'(6 - i)) begin
        n_fail++;
        $display("FAIL walk_q[%0d]: got %0d/%0d expected %0d/%0d", i, idxq_l, idxq_m, i, 6 - i);
      end
    end
  endtask

  task automatic test_zero();
    drive(7'h0, 1'b1);
    n_checks++;
    if (idx_l !== 3'd0 || val_l !== 1'b0 || mh_l !== 1'b0 || idx_m !== 3'd0) begin
      n_fail++;
      $display("FAIL zero_comb: got idx=%0d/%0d valid=%0b multi=%0b expected 0/0 0 0",
               idx_l, idx_m, val_l, mh_l);
    end
    tick();
    n_checks++;
    if (valq_l !== 1'b0 || valq_m !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_valid_q: got %0b/%0b expected 0", valq_l, valq_m);
    end
  endtask

  task automatic test_multi_hot();
    drive(7'b0000110, 1'b1);
    n_checks++;
    if (idx_l !== 3'd3 || mh_l !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_lsb: got idx=%0d multi=%0b expected 3 1", idx_l, mh_l);
    end
    n_checks++;
    if (idx_m !== 3'd5 || mh_m !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_msb: got idx=%0d multi=%0b expected 5 1", idx_m, mh_m);
    end
    n_checks++;
    if (err_l !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_err_early: got %0b expected 0", err_l);
    end
    tick();
    n_checks++;
    if (err_l !== 1'b1 || err_m !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_err_set: got %0b/%0b expected 1", err_l, err_m);
    end
    drive(7'(1 << 3), 1'b1);
    tick();
    tick();
    n_checks++;
    if (err_l !== 1'b1 || err_m !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_err_sticky: got %0b/%0b expected 1", err_l, err_m);
    end
  endtask

  task automatic test_registered();
    drive(7'(1 << 5), 1'b1);
    tick();
    drive(7'(1 << 2), 1'b1);
    n_checks++;
    if (idxq_l !== 3'd5 || valq_l !== 1'b1) begin
      n_fail++;
      $display("FAIL reg_first: got iq=%0d vq=%0b expected 5 1", idxq_l, valq_l);
    end
    tick();
    n_checks++;
    if (idxq_l !== 3'd2 || valq_l !== 1'b1) begin
      n_fail++;
      $display("FAIL reg_second: got iq=%0d vq=%0b expected 2 1", idxq_l, valq_l);
    end
  endtask

  task automatic test_reset_mid();
    drive(7'b0011000, 1'b1);
    tick();
    n_checks++;
    if (err_l !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre_err: got %0b expected 1", err_l);
    end
    drive(7'(1 << 4), 1'b0);
    n_checks++;
    if (idx_l !== 3'd4 || idx_m !== 3'd2 || val_l !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_comb: got idx=%0d/%0d valid=%0b expected 4/2 1", idx_l, idx_m, val_l);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (idxq_l !== 3'd0 || valq_l !== 1'b0 || err_l !== 1'b0 || idxq_m !== 3'd0) begin
        n_fail++;
        $display("FAIL rstmid_edge%0d: got iq=%0d/%0d vq=%0b err=%0b expected 0/0 0 0",
                 k, idxq_l, idxq_m, valq_l, err_l);
      end
    end
    drive(7'(1 << 4), 1'b1);
    tick();
    n_checks++;
    if (idxq_l !== 3'd4 || valq_l !== 1'b1 || err_l !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_release: got iq=%0d vq=%0b err=%0b expected 4 1 0", idxq_l, valq_l, err_l);
    end
  endtask

  task automatic test_random();
    logic [6:0] v;
    logic       r;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) v = 7'($urandom);
      else v = 7'(1 << $urandom_range(0, 6));
      r = ($urandom_range(0, 19) != 0);
      drive(v, r);
      n_checks++;
      if (int'(idx_l) != ref_idx(v, 1'b0) || int'(idx_m) != ref_idx(v, 1'b1) ||
          val_l !== (v != 0) || mh_l !== ref_multi(v) || mh_m !== ref_multi(v)) begin
        n_fail++;
        $display("FAIL rand_comb[%0d] v=%b: got idx=%0d/%0d valid=%0b multi=%0b expected %0d/%0d %0b %0b",
                 n, v, idx_l, idx_m, val_l, mh_l, ref_idx(v, 1'b0), ref_idx(v, 1'b1), v != 0, ref_multi(v));
      end
      tick();
      n_checks++;
      if (int'(idxq_l) != e_iq_l || int'(idxq_m) != e_iq_m || valq_l !== e_vq ||
          err_l !== e_err || err_m !== e_err) begin
        n_fail++;
        $display("FAIL rand_reg[%0d]: got iq=%0d/%0d vq=%0b err=%0b expected %0d/%0d %0b %0b",
                 n, idxq_l, idxq_m, valq_l, err_l, e_iq_l, e_iq_m, e_vq, e_err);
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    one_hot = '0;
    e_iq_l = 0; e_iq_m = 0; e_vq = 0; e_err = 0;
    test_reset();
    test_walk();
    test_zero();
    test_multi_hot();
    test_registered();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
